dm_responder: RTL and testbench



---
 rtl/dm_responder_pkg.sv | 7 +
 rtl/dm_responder_if.sv | 8 +
 rtl/dm_responder_tmr_core.sv | 67 ++++++
 rtl/dm_responder.sv | 41 ++++
 tb/tb_dm_responder.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/dm_responder_pkg.sv
// dm_responder_pkg: timer register map, CTRL fields and FSM states shared by the data responder
package dm_responder_pkg;
  localparam logic [1:0] TMR_CTRL = 2'd0, TMR_PRESET = 2'd1, TMR_COUNT = 2'd2;
  localparam int CTRL_EN = 0, CTRL_MODE = 1, CTRL_IM = 3;
  localparam logic [1:0] MODE_AUTO = 2'b01;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOAD = 2'd1, ST_CNT = 2'd2, ST_INT = 2'd3} tmr_state_e;
endpackage

// File: rtl/dm_responder_if.sv
// dm_responder_if: CPU M-stage data port plus timer interrupt line
interface dm_responder_if;
  logic [31:0] m_data_addr, m_data_wdata, m_data_rdata;
  logic [3:0] m_data_byteen;
  logic irq;
  modport master(output m_data_addr, m_data_wdata, m_data_byteen, input m_data_rdata, irq);
  modport slave(input m_data_addr, m_data_wdata, m_data_byteen, output m_data_rdata, irq);
endinterface

// File: rtl/dm_responder_tmr_core.sv
// dm_responder_tmr_core: countdown timer with CTRL/PRESET/COUNT registers and level irq
module dm_responder_tmr_core
  import dm_responder_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);
  tmr_state_e state, state_n;
  logic [3:0] ctrl, ctrl_n;
  logic [31:0] preset, count, count_n;
  logic irq_pend, pend_n, pulse, pulse_n, ctrl_we, auto_mode;
  assign ctrl_we = we && addr == TMR_CTRL;
  assign auto_mode = ctrl[CTRL_MODE +: 2] == MODE_AUTO;
  always_comb begin
    state_n = state;
    count_n = count;
    ctrl_n = ctrl;
    pend_n = irq_pend;
    pulse_n = 1'b0;
    case (state)
      ST_IDLE: state_n = ctrl[CTRL_EN] ? ST_LOAD : ST_IDLE;
      ST_LOAD: begin
        count_n = preset;
        state_n = ST_CNT;
      end
      ST_CNT:
        if (!ctrl[CTRL_EN]) state_n = ST_IDLE;
        else if (count == '0) state_n = ST_INT;
        else count_n = count - 32'd1;
      ST_INT: begin
        state_n = auto_mode ? ST_LOAD : ST_IDLE;
        ctrl_n[CTRL_EN] = ctrl[CTRL_EN] & auto_mode;
        pulse_n = auto_mode;
      end
    endcase
    // priority: auto-reload pulse clear < CPU CTRL write < INT set
    if (pulse) pend_n = 1'b0;
    if (ctrl_we) begin
      ctrl_n = wdata[3:0];
      pend_n = 1'b0;
    end
    if (state == ST_INT) pend_n = 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      ctrl <= '0;
      preset <= '0;
      count <= '0;
      irq_pend <= 1'b0;
      pulse <= 1'b0;
    end else begin
      state <= state_n;
      ctrl <= ctrl_n;
      count <= count_n;
      irq_pend <= pend_n;
      pulse <= pulse_n;
      if (we && addr == TMR_PRESET) preset <= wdata;
    end
  assign rdata = addr == TMR_CTRL ? {28'b0, ctrl} : addr == TMR_PRESET ? preset : addr == TMR_COUNT ? count : '0;
  assign irq = irq_pend & ctrl[CTRL_IM];
endmodule

// File: rtl/dm_responder.sv
// dm_responder: decodes CPU data accesses onto a byte-enabled RAM and the timer block
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int          DM_WORDS = 3072,
  parameter logic [31:0] DM_BASE  = 32'h0000_0000,
  parameter logic [31:0] TMR_BASE = 32'h0000_7F00
) (
  input logic            clk,
  input logic            rst_n,
  dm_responder_if.slave  bus
);
  localparam int AW = $clog2(DM_WORDS);
  logic [31:0] mem [DM_WORDS];
  logic [29:0] word, dm_off, tmr_off;
  logic [AW-1:0] idx;
  logic [31:0] tmr_rdata;
  logic dm_hit, tmr_hit, unused_lsb;
  assign unused_lsb = ^bus.m_data_addr[1:0];
  assign word = bus.m_data_addr[31:2];
  assign dm_off = word - DM_BASE[31:2];
  assign tmr_off = word - TMR_BASE[31:2];
  assign dm_hit = dm_off < 30'(DM_WORDS);
  assign tmr_hit = tmr_off < 30'd3;
  assign idx = dm_off[AW-1:0];
  dm_responder_tmr_core u_tmr (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (tmr_hit && bus.m_data_byteen == 4'hF),
    .addr  (tmr_off[1:0]),
    .wdata (bus.m_data_wdata),
    .rdata (tmr_rdata),
    .irq   (bus.irq)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < DM_WORDS; i++) mem[i] <= '0;
    else if (dm_hit)
      for (int b = 0; b < 4; b++)
        if (bus.m_data_byteen[b]) mem[idx][8*b +: 8] <= bus.m_data_wdata[8*b +: 8];
  assign bus.m_data_rdata = dm_hit ? mem[idx] : tmr_hit ? tmr_rdata : '0;
endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: vector table, timed timer sequences and randomized RAM/register traffic vs a reference model
module tb_dm_responder;
  logic clk = 1'b0, rst_n = 1'b1;
  int nerr = 0, nchk = 0;
  dm_responder_if bus();
  dm_responder u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  localparam logic [31:0] A_CTRL = 32'h7F00, A_PRE = 32'h7F04, A_CNT = 32'h7F08;
  typedef struct { logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; logic [31:0] exp; } vec_t;
  vec_t vecs[12];
  logic [31:0] m [3072];
  logic [31:0] m_preset, v, d, a, mask;
  logic [3:0] m_ctrl, be;
  int idx, p;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [31:0] ad, input logic [31:0] dat, input logic [3:0] ben);
    bus.m_data_addr = ad;
    bus.m_data_wdata = dat;
    bus.m_data_byteen = ben;
    step();
    bus.m_data_byteen = 4'h0;
  endtask
  task automatic chk_rd(input string name, input logic [31:0] ad, input logic [31:0] exp);
    bus.m_data_addr = ad;
    bus.m_data_byteen = 4'h0;
    #1;
    check(name, bus.m_data_rdata, exp);
  endtask

  initial begin
    bus.m_data_addr = '0;
    bus.m_data_wdata = '0;
    bus.m_data_byteen = '0;
    vecs[0]  = '{32'h0000, 32'h11223344, 4'hF, 32'h11223344};
    vecs[1]  = '{32'h0000, 32'h0000AA00, 4'h2, 32'h1122AA44};
    vecs[2]  = '{32'h4000, 32'hDEADBEEF, 4'hF, 32'h0};
    vecs[3]  = '{32'h7F04, 32'h00000005, 4'h3, 32'h0};
    vecs[4]  = '{32'h7F04, 32'h12345678, 4'hF, 32'h12345678};
    vecs[5]  = '{32'h7F08, 32'h0000FFFF, 4'hF, 32'h0};
    vecs[6]  = '{32'h7F00, 32'hFFFFFFF6, 4'hF, 32'h6};
    vecs[7]  = '{32'h2FFC, 32'hCAFEF00D, 4'hF, 32'hCAFEF00D};
    vecs[8]  = '{32'h3000, 32'h00000001, 4'hF, 32'h0};
    vecs[9]  = '{32'h7F0C, 32'h00000001, 4'hF, 32'h0};
    vecs[10] = '{32'h0003, 32'h99000000, 4'h8, 32'h9922AA44};
    vecs[11] = '{32'h7F00, 32'h00000000, 4'hF, 32'h0};
    #2 rst_n = 1'b0;
    #1;
    chk_rd("rst_ram", 32'h0, 32'h0);
    chk_rd("rst_ctrl", A_CTRL, 32'h0);
    chk_rd("rst_count", A_CNT, 32'h0);
    check("rst_irq", {31'b0, bus.irq}, 32'h0);
    #18 rst_n = 1'b1;
    step();
    for (int i = 0; i < 12; i++) begin
      wr(vecs[i].addr, vecs[i].wdata, vecs[i].be);
      chk_rd($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
    end

    p = 5;
    wr(A_PRE, 32'(p), 4'hF);
    wr(A_CTRL, 32'h9, 4'hF);
    for (int k = 0; k <= 12; k++) begin
      chk_rd($sformatf("os_count_k%0d", k), A_CNT, (k < 2 || k > p + 2) ? 32'h0 : 32'(p - (k - 2)));
      check($sformatf("os_irq_k%0d", k), {31'b0, bus.irq}, {31'b0, k >= p + 4});
      step();
    end
    chk_rd("os_ctrl_en_clr", A_CTRL, 32'h8);
    wr(A_CTRL, 32'h0, 4'hF);
    check("os_irq_clear", {31'b0, bus.irq}, 32'h0);

    p = 2;
    wr(A_PRE, 32'(p), 4'hF);
    wr(A_CTRL, 32'hB, 4'hF);
    for (int k = 0; k <= 17; k++) begin
      int ph;
      ph = (k - 2) % (p + 3);
      chk_rd($sformatf("ar_count_k%0d", k), A_CNT, (k < 2 || ph > p) ? 32'h0 : 32'(p - ph));
      check($sformatf("ar_irq_k%0d", k), {31'b0, bus.irq}, {31'b0, k >= 2 && ph == p + 2});
      step();
    end
    wr(A_CTRL, 32'h0, 4'hF);
    repeat (3) step();

    wr(A_PRE, 32'd100, 4'hF);
    wr(A_CTRL, 32'h1, 4'hF);
    for (int k = 0; k <= 11; k++) begin
      if (k >= 2) chk_rd($sformatf("dis_count_k%0d", k), A_CNT, 32'(100 - (k - 2)));
      if (k < 11) step();
    end
    wr(A_CTRL, 32'h0, 4'hF);
    for (int j = 0; j < 8; j++) begin
      chk_rd($sformatf("dis_hold_%0d", j), A_CNT, 32'd90);
      check($sformatf("dis_irq_%0d", j), {31'b0, bus.irq}, 32'h0);
      step();
    end

    wr(32'h10, 32'hA5A5A5A5, 4'hF);
    wr(A_PRE, 32'd4, 4'hF);
    wr(A_CTRL, 32'hB, 4'hF);
    for (int k = 0; k < 10; k++) begin
      if (k == 8) check("ar_irq_pre_rst", {31'b0, bus.irq}, 32'h1);
      step();
    end
    chk_rd("pre_rst_count", A_CNT, 32'd3);
    rst_n = 1'b0;
    #1;
    check("arst_irq", {31'b0, bus.irq}, 32'h0);
    chk_rd("arst_count", A_CNT, 32'h0);
    chk_rd("arst_ctrl", A_CTRL, 32'h0);
    chk_rd("arst_ram", 32'h10, 32'h0);
    wr(32'h10, 32'hFFFFFFFF, 4'hF);
    #3 rst_n = 1'b1;
    step();
    chk_rd("post_rst_ram", 32'h10, 32'h0);
    chk_rd("post_rst_count", A_CNT, 32'h0);

    for (int i = 0; i < 3072; i++) m[i] = '0;
    m_preset = '0;
    m_ctrl = '0;
    for (int it = 0; it < 400; it++) begin
      d = $urandom;
      be = 4'($urandom_range(0, 15));
      idx = $urandom_range(0, 3071);
      case ($urandom_range(0, 4))
        0: begin
          wr(32'(idx * 4 + $urandom_range(0, 3)), d, be);
          mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
          m[idx] = (m[idx] & ~mask) | (d & mask);
          chk_rd($sformatf("rnd_wr_w%0d", idx), 32'(idx * 4), m[idx]);
        end
        1: chk_rd($sformatf("rnd_rd_w%0d", idx), 32'(idx * 4), m[idx]);
        2: begin
          wr(A_PRE, d, be);
          if (be == 4'hF) m_preset = d;
          chk_rd("rnd_preset", A_PRE, m_preset);
        end
        3: begin
          wr(A_CTRL, d & 32'hFFFF_FFFE, be);
          if (be == 4'hF) m_ctrl = d[3:0] & 4'hE;
          chk_rd("rnd_ctrl", A_CTRL, {28'b0, m_ctrl});
        end
        default: begin
          a = $urandom_range(0, 1) ? 32'($urandom_range(32'h3000, 32'h7EFF)) : 32'($urandom_range(32'h7F0C, 32'hFFFF_FFFF));
          wr(a, d, 4'hF);
          chk_rd("rnd_unmapped", a, 32'h0);
        end
      endcase
      check("rnd_irq", {31'b0, bus.irq}, 32'h0);
    end
    chk_rd("rnd_count_idle", A_CNT, 32'h0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
